// File: rtl/seg_arb_pkg.sv
// Shared definitions for the 7-segment display arbiter.
//   arb_state_t : arbiter FSM states
//   SEG_BLANK   : all segments off (active-low)
//   SEG_DIGIT   : active-low {a,b,c,d,e,f,g} patterns for digits 0..7
package seg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_DIGIT [0:7] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111   // 7
  };

endpackage

// File: rtl/seg7_digit_decoder.sv
// Combinational 3-bit digit to active-low 7-segment decoder with blanking.
//   digit : value to show (0..7)
//   blank : 1 = all segments off, overrides digit
//   seg   : active-low segments {a,b,c,d,e,f,g}
module seg7_digit_decoder
  import seg_arb_pkg::*;
(
  input  logic [2:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      seg = SEG_DIGIT[digit];
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares one 7-segment display between N_REQ requesters, one owner at a time.
// The owner index is shown as an active-low digit; the display is blank when
// nobody owns it. Fixed-priority (highest index) or round-robin arbitration is
// chosen per arbitration by rr_mode. A hold timer revokes a grant that has run
// HOLD_MAX cycles while other requesters are waiting (HOLD_MAX = 0 disables it).
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   req       : request levels, held high while the display is wanted
//   rr_mode   : 1 = round-robin, 0 = fixed priority (sampled when arbitrating)
//   gnt       : registered one-hot grant, zero when there is no owner
//   gnt_valid : high while an owner exists (equals |gnt)
//   gnt_id    : owner index; keeps the last owner while gnt_valid is low
//   seg       : active-low segments, digit gnt_id or blank
//   preempt   : high during the grant cycle in which a timeout revokes the grant
module seg_display_arbiter
  import seg_arb_pkg::*;
#(
  parameter int N_REQ    = 8,    // 2..8
  parameter int HOLD_MAX = 200,  // 0 disables preemption
  parameter int CNT_W    = 8     // HOLD_MAX <= 2**CNT_W - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             rr_mode,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [2:0]       gnt_id,
  output logic [6:0]       seg,
  output logic             preempt
);

  localparam bit               HOLD_EN  = (HOLD_MAX > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
  localparam logic [2:0]       LAST_ID  = 3'(N_REQ - 1);
  localparam logic [N_REQ-1:0] BIT0     = N_REQ'(1);

  arb_state_t       state;
  logic [2:0]       rr_ptr;
  logic [CNT_W-1:0] hold_cnt;
  logic [2:0]       winner;
  logic             owner_req;
  logic             others_req;
  logic             timeout;

  // Fixed mode keeps the last (highest) set index. Round-robin scans the
  // offsets from the top down so the smallest offset from ptr wins.
  function automatic logic [2:0] pick_winner(input logic [N_REQ-1:0] r,
                                             input logic             rr,
                                             input logic [2:0]       ptr);
    logic [2:0] w;
    int         idx;
    w = '0;
    if (!rr) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (((r >> i) & BIT0) != '0) w = 3'(i);
      end
    end else begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        idx = int'(ptr) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (((r >> idx) & BIT0) != '0) w = 3'(idx);
      end
    end
    return w;
  endfunction

  assign winner     = pick_winner(req, rr_mode, rr_ptr);
  // gnt is one-hot, so masking with it selects the owner's request bit.
  assign owner_req  = |(req & gnt);
  assign others_req = |(req & ~gnt);
  assign timeout    = HOLD_EN && (hold_cnt == CNT_LAST);

  // Decoded from registered state plus the current waiters so the pulse lands
  // in the revoked grant's last cycle; an owner that is already dropping its
  // request releases normally and never sees a pulse.
  assign preempt = (state == GRANT) && owner_req && others_req && timeout;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      rr_ptr    <= '0;
      hold_cnt  <= '0;
    end else begin
      case (state)
        IDLE, RELEASE: begin
          if (|req) begin
            gnt       <= BIT0 << winner;
            gnt_id    <= winner;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
            state     <= GRANT;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (!owner_req || preempt) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            // Updated on entry to RELEASE so that cycle's arbitration already
            // starts one past the departing owner.
            rr_ptr    <= (gnt_id == LAST_ID) ? 3'd0 : gnt_id + 3'd1;
            state     <= RELEASE;
          end else if (hold_cnt != CNT_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= '0;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

  seg7_digit_decoder u_decoder (
    .digit (gnt_id),
    .blank (~gnt_valid),
    .seg   (seg)
  );

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter (N_REQ=8, HOLD_MAX=4).
// The driver applies one row per cycle just after the rising edge and queues
// the outputs expected for that cycle; the monitor pops one entry per falling
// edge and compares.
module tb_seg_display_arbiter;

  localparam int N_REQ    = 8;
  localparam int HOLD_MAX = 4;
  localparam int CNT_W    = 8;

  localparam logic [6:0] SEG_REF [0:7] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111
  };

  typedef struct {
    int         row;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       pre;
    logic [2:0] ptr;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [N_REQ-1:0] req;
  logic             rr_mode;
  logic [N_REQ-1:0] gnt;
  logic             gnt_valid;
  logic [2:0]       gnt_id;
  logic [6:0]       seg;
  logic             preempt;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   row_no   = 0;

  seg_display_arbiter #(
    .N_REQ    (N_REQ),
    .HOLD_MAX (HOLD_MAX),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rr_mode   (rr_mode),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .seg       (seg),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs for this cycle and queue the outputs expected in it.
  task automatic cyc(input logic [7:0] r, input logic m,
                     input logic [7:0] e_gnt, input logic [2:0] e_id,
                     input logic e_pre, input logic [2:0] e_ptr);
    exp_t e;
    @(posedge clk);
    #1;
    req     = r;
    rr_mode = m;
    row_no++;
    e.row = row_no;
    e.gnt = e_gnt;
    e.id  = e_id;
    e.pre = e_pre;
    e.ptr = e_ptr;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [6:0] e_seg;
      mon_e = exp_q.pop_front();
      e_seg = (mon_e.gnt != 8'h00) ? SEG_REF[mon_e.id] : 7'h7F;
      check($sformatf("row%0d gnt", mon_e.row), 32'(gnt), 32'(mon_e.gnt));
      check($sformatf("row%0d gnt_valid", mon_e.row), 32'(gnt_valid), 32'(mon_e.gnt != 8'h00));
      check($sformatf("row%0d gnt_id", mon_e.row), 32'(gnt_id), 32'(mon_e.id));
      check($sformatf("row%0d seg", mon_e.row), 32'(seg), 32'(e_seg));
      check($sformatf("row%0d preempt", mon_e.row), 32'(preempt), 32'(mon_e.pre));
      check($sformatf("row%0d rr_ptr", mon_e.row), 32'(dut.rr_ptr), 32'(mon_e.ptr));
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: actual still running, expected finish before 50000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    req     = 8'hFF;
    rr_mode = 1'b0;

    // Reset held with every requester active: no owner, blank display.
    cyc(8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 3'd0);
    cyc(8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 3'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    // First edge after reset: fixed priority picks 7.
    cyc(8'h00, 1'b0, 8'h80, 3'd7, 1'b0, 3'd0);
    cyc(8'h00, 1'b0, 8'h00, 3'd7, 1'b0, 3'd0);  // RELEASE, ptr (7+1)%8
    cyc(8'h81, 1'b1, 8'h00, 3'd7, 1'b0, 3'd0);  // IDLE

    // Round-robin with 0 and 7 requesting; owner drops after 3 grant cycles.
    for (int pass = 0; pass < 2; pass++) begin
      cyc(8'h81, 1'b1, 8'h01, 3'd0, 1'b0, 3'd0);
      cyc(8'h81, 1'b1, 8'h01, 3'd0, 1'b0, 3'd0);
      cyc(8'h80, 1'b1, 8'h01, 3'd0, 1'b0, 3'd0);
      cyc(8'h81, 1'b1, 8'h00, 3'd0, 1'b0, 3'd1);
      cyc(8'h81, 1'b1, 8'h80, 3'd7, 1'b0, 3'd1);
      cyc(8'h81, 1'b1, 8'h80, 3'd7, 1'b0, 3'd1);
      if (pass == 0) begin
        cyc(8'h01, 1'b1, 8'h80, 3'd7, 1'b0, 3'd1);
        cyc(8'h81, 1'b1, 8'h00, 3'd7, 1'b0, 3'd0);
      end else begin
        cyc(8'h00, 1'b1, 8'h80, 3'd7, 1'b0, 3'd1);
        cyc(8'h00, 1'b0, 8'h00, 3'd7, 1'b0, 3'd0);
      end
    end
    cyc(8'h14, 1'b0, 8'h00, 3'd7, 1'b0, 3'd0);  // IDLE

    // Fixed priority: 4 beats 2; dropping 4 gives one blank cycle, then 2.
    cyc(8'h14, 1'b0, 8'h10, 3'd4, 1'b0, 3'd0);
    cyc(8'h04, 1'b0, 8'h10, 3'd4, 1'b0, 3'd0);
    cyc(8'h04, 1'b0, 8'h00, 3'd4, 1'b0, 3'd5);
    cyc(8'h00, 1'b0, 8'h04, 3'd2, 1'b0, 3'd5);
    cyc(8'h03, 1'b0, 8'h00, 3'd2, 1'b0, 3'd3);

    // Preemption: 1 owns for exactly 4 cycles, pulse on the 4th, wins again.
    cyc(8'h03, 1'b0, 8'h02, 3'd1, 1'b0, 3'd3);
    cyc(8'h03, 1'b0, 8'h02, 3'd1, 1'b0, 3'd3);
    cyc(8'h03, 1'b0, 8'h02, 3'd1, 1'b0, 3'd3);
    cyc(8'h03, 1'b0, 8'h02, 3'd1, 1'b1, 3'd3);
    cyc(8'h02, 1'b0, 8'h00, 3'd1, 1'b0, 3'd2);

    // Timeout with nobody waiting: stays granted until 0 shows up.
    for (int i = 0; i < 5; i++) begin
      cyc(8'h02, 1'b0, 8'h02, 3'd1, 1'b0, 3'd2);
    end
    cyc(8'h03, 1'b0, 8'h02, 3'd1, 1'b1, 3'd2);
    cyc(8'h03, 1'b0, 8'h00, 3'd1, 1'b0, 3'd2);

    // Owner drop on the timeout cycle: RELEASE without a pulse.
    cyc(8'h03, 1'b0, 8'h02, 3'd1, 1'b0, 3'd2);
    cyc(8'h03, 1'b0, 8'h02, 3'd1, 1'b0, 3'd2);
    cyc(8'h03, 1'b0, 8'h02, 3'd1, 1'b0, 3'd2);
    cyc(8'h01, 1'b0, 8'h02, 3'd1, 1'b0, 3'd2);
    cyc(8'h01, 1'b0, 8'h00, 3'd1, 1'b0, 3'd2);
    cyc(8'h01, 1'b0, 8'h01, 3'd0, 1'b0, 3'd2);

    // Reset mid-grant: outputs return to reset values before the next edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst gnt", 32'(gnt), 32'h0);
    check("async_rst gnt_valid", 32'(gnt_valid), 32'h0);
    check("async_rst gnt_id", 32'(gnt_id), 32'h0);
    check("async_rst seg", 32'(seg), 32'h7F);
    check("async_rst preempt", 32'(preempt), 32'h0);

    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
